// File: rtl/result_drain.sv
// Snapshots c00..c11 on capture and streams them as bytes on a registered valid/ready port; byte 0 is valid the cycle after capture and holds while !out_ready.
// Define SAT8_EN to send each word saturated to one signed byte instead of as full RES_WIDTH words.
module result_drain #(
   parameter int RES_WIDTH = 16,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 capture,
   input  logic [RES_WIDTH-1:0] c00,
   input  logic [RES_WIDTH-1:0] c01,
   input  logic [RES_WIDTH-1:0] c10,
   input  logic [RES_WIDTH-1:0] c11,
   input  logic                 out_ready,
   input  logic                 clr_err,
   output logic [7:0]           out_data,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 overrun
);

`ifdef SAT8_EN
   localparam int BPW = 1;
`else
   localparam int BPW = RES_WIDTH / 8;
`endif
   localparam int FB = 4 * BPW;
   localparam int IW = (FB > 1) ? $clog2(FB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(FB - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d, idx_nxt;
   logic [7:0]      frame_q [FB];
   logic [7:0]      frame_d [FB];
   logic [7:0]      new_bytes [FB];
   logic [7:0]      out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            done_q, done_d;
   logic            overrun_q, overrun_d;
   logic [RES_WIDTH-1:0] words [4];
   logic            hs, last_hs, accept;

`ifdef SAT8_EN
   localparam logic signed [RES_WIDTH-1:0] MAX8 = RES_WIDTH'(127);
   localparam logic signed [RES_WIDTH-1:0] MIN8 = RES_WIDTH'(-128);

   function automatic logic [7:0] sat8(input logic [RES_WIDTH-1:0] v);
      if ($signed(v) > MAX8)
         return 8'h7F;
      else if ($signed(v) < MIN8)
         return 8'h80;
      else
         return v[7:0];
   endfunction
`endif

   always_comb begin
      words[0] = c00;
      words[1] = c01;
      words[2] = c10;
      words[3] = c11;
   end

   // Frame image built from the live inputs; only written into frame_q on an accepted capture.
   always_comb begin
      for (int i = 0; i < FB; i++) new_bytes[i] = 8'h00;
`ifdef SAT8_EN
      for (int w = 0; w < 4; w++) new_bytes[w] = sat8(words[w]);
`else
      for (int w = 0; w < 4; w++) begin
         for (int b = 0; b < BPW; b++) begin
            new_bytes[w*BPW + b] = LSB_FIRST ? words[w][8*b +: 8]
                                             : words[w][8*(BPW-1-b) +: 8];
         end
      end
`endif
   end

   assign hs      = (state_q == SEND) && out_valid_q && out_ready;
   assign last_hs = hs && (idx_q == LAST_IDX);
   assign accept  = capture && ((state_q == IDLE) || last_hs);
   assign idx_nxt = idx_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      frame_d     = frame_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = last_hs;
      overrun_d   = overrun_q;

      if (accept) begin
         state_d     = SEND;
         frame_d     = new_bytes;
         idx_d       = '0;
         out_data_d  = new_bytes[0];
         out_valid_d = 1'b1;
      end else if (last_hs) begin
         state_d     = IDLE;
         idx_d       = '0;
         out_valid_d = 1'b0;
      end else if (hs) begin
         idx_d      = idx_nxt;
         out_data_d = frame_q[idx_nxt];
      end

      // A dropped capture outranks a simultaneous clear.
      if (capture && (state_q == SEND) && !last_hs)
         overrun_d = 1'b1;
      else if (clr_err)
         overrun_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < FB; i++) frame_q[i] <= 8'h00;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
         for (int i = 0; i < FB; i++) frame_q[i] <= frame_d[i];
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == SEND);
   assign done      = done_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: frame order, stalls, overrun, back-to-back frames, mid-frame reset.
module tb_result_drain;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        capture = 1'b0;
   logic [15:0] c00 = '0, c01 = '0, c10 = '0, c11 = '0;
   logic        out_ready = 1'b0;
   logic        clr_err = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid, busy, done, overrun;

   int checks = 0;
   int passes = 0;

   result_drain #(.RES_WIDTH(16), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .capture(capture),
      .c00(c00), .c01(c01), .c10(c10), .c11(c11),
      .out_ready(out_ready), .clr_err(clr_err),
      .out_data(out_data), .out_valid(out_valid), .busy(busy),
      .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
      c00 = a; c01 = b; c10 = c; c11 = d;
   endtask

   logic [7:0] exp_a [8] = '{8'h34, 8'h12, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h80};
   logic [7:0] exp_b [8] = '{8'hB2, 8'hA1, 8'h01, 8'h00, 8'hFF, 8'h7F, 8'hD4, 8'hC3};
   logic [7:0] exp_c [8] = '{8'h66, 8'h55, 8'h88, 8'h77, 8'h00, 8'h00, 8'h01, 8'h01};

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({out_valid, busy, done, overrun, out_data} !== 12'h000)
         $display("FAIL reset_state got v%0b b%0b d%0b o%0b data %h, want all 0",
                  out_valid, busy, done, overrun, out_data);
      else passes++;
   endtask

`ifndef SAT8_EN
   task automatic test_basic();
      load(16'h1234, 16'hFFFF, 16'h0080, 16'h8000);
      out_ready = 1'b1;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || out_data !== exp_a[i])
            $display("FAIL basic_byte%0d got v%0b b%0b d%0b data %h, want v1 b1 d0 data %h",
                     i, out_valid, busy, done, out_data, exp_a[i]);
         else passes++;
         tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL basic_end got d%0b b%0b v%0b, want d1 b0 v0", done, busy, out_valid);
      else passes++;
      tick();
      checks++;
      if (done !== 1'b0)
         $display("FAIL basic_done_width got %0b, want 0", done);
      else passes++;
   endtask

   task automatic test_stall();
      int n = 0;
      int k = 0;
      load(16'h1234, 16'hFFFF, 16'h0080, 16'h8000);
      out_ready = 1'b1;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      while (n < 8 && k < 40) begin
         checks++;
         if (out_valid !== 1'b1 || done !== 1'b0 || out_data !== exp_a[n])
            $display("FAIL stall_cycle%0d got v%0b d%0b data %h, want v1 d0 data %h",
                     k, out_valid, done, out_data, exp_a[n]);
         else passes++;
         out_ready = (k % 3 == 0);
         tick();
         if (out_ready) n++;
         k++;
      end
      out_ready = 1'b1;
      checks++;
      if (n != 8 || done !== 1'b1 || busy !== 1'b0)
         $display("FAIL stall_end got transfers %0d d%0b b%0b, want 8 d1 b0", n, done, busy);
      else passes++;
      tick();
   endtask

   task automatic test_overrun();
      load(16'h1234, 16'hFFFF, 16'h0080, 16'h8000);
      out_ready = 1'b1;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_a[i])
            $display("FAIL ovr_byte%0d got v%0b data %h, want v1 data %h",
                     i, out_valid, out_data, exp_a[i]);
         else passes++;
         capture = (i == 3);
         if (i == 3) load(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
         tick();
      end
      capture = 1'b0;
      checks++;
      if (overrun !== 1'b1 || done !== 1'b1 || busy !== 1'b0)
         $display("FAIL ovr_flag got o%0b d%0b b%0b, want o1 d1 b0", overrun, done, busy);
      else passes++;
      tick(); tick();
      checks++;
      if (overrun !== 1'b1)
         $display("FAIL ovr_sticky got %0b, want 1", overrun);
      else passes++;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checks++;
      if (overrun !== 1'b0)
         $display("FAIL ovr_clear got %0b, want 0", overrun);
      else passes++;
      load(16'h5566, 16'h7788, 16'h0000, 16'h0101);
      capture = 1'b1;
      tick();
      capture = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_c[i])
            $display("FAIL ovr_idle_byte%0d got v%0b data %h, want v1 data %h",
                     i, out_valid, out_data, exp_c[i]);
         else passes++;
         capture = (i == 2);
         clr_err = (i == 2);
         tick();
         if (i == 2) begin
            checks++;
            if (overrun !== 1'b1)
               $display("FAIL ovr_set_wins got %0b, want 1", overrun);
            else passes++;
         end
      end
      capture = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   task automatic test_back_to_back();
      load(16'h1234, 16'hFFFF, 16'h0080, 16'h8000);
      out_ready = 1'b1;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_a[i])
            $display("FAIL b2b_first_byte%0d got v%0b data %h, want v1 data %h",
                     i, out_valid, out_data, exp_a[i]);
         else passes++;
         capture = (i == 7);
         if (i == 7) load(16'hA1B2, 16'h0001, 16'h7FFF, 16'hC3D4);
         tick();
      end
      capture = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b1 || out_data !== exp_b[0] || overrun !== 1'b0)
         $display("FAIL b2b_seam got d%0b b%0b v%0b o%0b data %h, want d1 b1 v1 o0 data %h",
                  done, busy, out_valid, overrun, out_data, exp_b[0]);
      else passes++;
      load(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || done !== 1'b0 || out_data !== exp_b[i])
               $display("FAIL b2b_second_byte%0d got v%0b d%0b data %h, want v1 d0 data %h",
                        i, out_valid, done, out_data, exp_b[i]);
            else passes++;
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0)
         $display("FAIL b2b_end got d%0b b%0b, want d1 b0", done, busy);
      else passes++;
      tick();
   endtask

   task automatic test_mid_reset();
      load(16'h1234, 16'hFFFF, 16'h0080, 16'h8000);
      out_ready = 1'b1;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      for (int i = 0; i < 4; i++) begin
         capture = (i == 1);
         tick();
      end
      capture = 1'b0;
      checks++;
      if (overrun !== 1'b1 || out_data !== exp_a[4])
         $display("FAIL rst_pre got o%0b data %h, want o1 data %h", overrun, out_data, exp_a[4]);
      else passes++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || done !== 1'b0)
         $display("FAIL rst_abort got v%0b b%0b o%0b d%0b, want all 0",
                  out_valid, busy, overrun, done);
      else passes++;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_a[i])
            $display("FAIL rst_restart_byte%0d got v%0b data %h, want v1 data %h",
                     i, out_valid, out_data, exp_a[i]);
         else passes++;
         tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0)
         $display("FAIL rst_restart_end got d%0b b%0b, want d1 b0", done, busy);
      else passes++;
      tick();
   endtask
`else
   logic [7:0] exp_s [4] = '{8'h7F, 8'h80, 8'h05, 8'hFB};

   task automatic test_sat8();
      load(16'd300, 16'hFED4, 16'd5, 16'hFFFB);
      out_ready = 1'b1;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || done !== 1'b0 || out_data !== exp_s[i])
            $display("FAIL sat8_byte%0d got v%0b d%0b data %h, want v1 d0 data %h",
                     i, out_valid, done, out_data, exp_s[i]);
         else passes++;
         tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0)
         $display("FAIL sat8_end got d%0b b%0b, want d1 b0", done, busy);
      else passes++;
      tick();
   endtask
`endif

   initial begin
      #1;
      test_reset();
`ifndef SAT8_EN
      test_basic();
      test_stall();
      test_overrun();
      test_back_to_back();
      test_mid_reset();
`else
      test_sat8();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
